// File: rtl/pcie_datalink_pkg.sv
// Shared data link layer definitions: DLLP type codes, DL/TX state enums,
// DLLP body packing union and the DLLP CRC16 helper.
package pcie_datalink_pkg;

  localparam logic [7:0] DLLP_ACK        = 8'h00;
  localparam logic [7:0] DLLP_NAK        = 8'h10;
  localparam logic [7:0] DLLP_INITFC1_P  = 8'h40;
  localparam logic [7:0] DLLP_INITFC1_NP = 8'h50;
  localparam logic [7:0] DLLP_INITFC1_C  = 8'h60;
  localparam logic [7:0] DLLP_INITFC2_P  = 8'hC0;
  localparam logic [7:0] DLLP_INITFC2_NP = 8'hD0;
  localparam logic [7:0] DLLP_INITFC2_C  = 8'hE0;
  localparam logic [7:0] DLLP_UPDFC_P    = 8'h80;
  localparam logic [7:0] DLLP_UPDFC_NP   = 8'h90;
  localparam logic [7:0] DLLP_UPDFC_C    = 8'hA0;

  localparam logic [15:0] DLLP_CRC_POLY  = 16'h100B;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_FC1      = 2'd1,
    DL_FC2      = 2'd2,
    DL_ACTIVE   = 2'd3
  } dl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_BODY = 2'd1,
    TX_CRC  = 2'd2
  } tx_state_e;

  // Fields listed MSB first, so dllp_type lands in byte0 = tdata[7:0]
  typedef struct packed {
    logic [7:0] data_lo;
    logic [1:0] hdr_lo;
    logic [1:0] rsvd1;
    logic [3:0] data_hi;
    logic [1:0] rsvd0;
    logic [5:0] hdr_hi;
    logic [7:0] dllp_type;
  } dllp_fc_t;

  typedef struct packed {
    logic [7:0] seq_lo;
    logic [3:0] rsvd1;
    logic [3:0] seq_hi;
    logic [7:0] rsvd0;
    logic [7:0] dllp_type;
  } dllp_acknak_t;

  typedef union packed {
    logic [31:0]  raw;
    dllp_fc_t     fc;
    dllp_acknak_t an;
  } dllp_union_t;

  function automatic logic [31:0] pack_fc(input logic [7:0] t, input logic [7:0] hdr,
                                          input logic [11:0] data);
    dllp_union_t u;
    u.fc.dllp_type = t;
    u.fc.hdr_hi    = hdr[7:2];
    u.fc.rsvd0     = 2'b00;
    u.fc.data_hi   = data[11:8];
    u.fc.rsvd1     = 2'b00;
    u.fc.hdr_lo    = hdr[1:0];
    u.fc.data_lo   = data[7:0];
    return u.raw;
  endfunction

  function automatic logic [31:0] pack_acknak(input logic is_ack, input logic [11:0] seq);
    dllp_union_t u;
    u.an.dllp_type = is_ack ? DLLP_ACK : DLLP_NAK;
    u.an.rsvd0     = 8'h00;
    u.an.seq_hi    = seq[11:8];
    u.an.rsvd1     = 4'h0;
    u.an.seq_lo    = seq[7:0];
    return u.raw;
  endfunction

  // Serial LFSR, byte0 first and bit0 of each byte first
  function automatic logic [15:0] crc16_dllp(input logic [15:0] crc_in, input logic [31:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ DLLP_CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// Combinational DLLP CRC16 over one 32-bit DLLP body.
module pcie_datalink_crc
  import pcie_datalink_pkg::*;
(
  input  logic [15:0] crcIn,
  input  logic [31:0] data,
  output logic [15:0] crcOut
);

  assign crcOut = crc16_dllp(crcIn, data);

endmodule

// File: rtl/dllp_tx_scheduler.sv
// DLLP transmit controller: InitFC1/InitFC2 link init, then Ack/Nak and UpdateFC scheduling.
// Optional periodic UpdateFC timer enabled by defining DLLP_UPDATEFC_TIMER_EN.
module dllp_tx_scheduler
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int USER_WIDTH         = 4,
  parameter int UPDATE_FC_INTERVAL = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,
  input  logic                  fc1_values_stored_i,
  input  logic                  fc2_values_stored_i,
  input  logic                  ack_nak_vld_i,
  input  logic                  ack_nak_is_ack_i,
  input  logic [11:0]           ack_nak_seq_i,
  input  logic [2:0]            update_fc_req_i,
  input  logic [7:0]            rx_fc_ph_i,
  input  logic [7:0]            rx_fc_nph_i,
  input  logic [7:0]            rx_fc_cplh_i,
  input  logic [11:0]           rx_fc_pd_i,
  input  logic [11:0]           rx_fc_npd_i,
  input  logic [11:0]           rx_fc_cpld_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  dl_up_o,
  output logic [1:0]            dl_state_o
);

  dl_state_e             r_dl_state;
  tx_state_e             r_tx_state;
  logic [1:0]            r_fc_idx;
  logic                  r_cur_is_upd;
  logic [2:0]            r_cur_upd;
  logic [31:0]           r_body;
  logic                  r_ack_pend;
  logic                  r_ack_is_ack;
  logic [11:0]           r_ack_seq;
  logic [2:0]            r_upd_pend;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [USER_WIDTH-1:0] r_tuser;
  logic                  r_dl_up;

  logic        w_active;
  logic        w_in_init;
  logic        w_load;
  logic        w_sel_ack;
  logic [2:0]  w_sel_upd;
  logic [1:0]  w_cls;
  logic [7:0]  w_base;
  logic [7:0]  w_type;
  logic [7:0]  w_hdr;
  logic [11:0] w_data;
  logic [31:0] w_load_body;
  logic        w_ack_is_ack;
  logic [11:0] w_ack_seq;
  logic [2:0]  w_upd_clr;
  logic [2:0]  w_upd_set;
  logic [2:0]  w_timer_hit;
  logic [15:0] w_crc;

  assign w_active  = (r_dl_state == DL_ACTIVE);
  assign w_in_init = (r_dl_state == DL_FC1) || (r_dl_state == DL_FC2);

  // A request arriving on the load cycle is the newest one, so it wins over the slot
  assign w_ack_is_ack = ack_nak_vld_i ? ack_nak_is_ack_i : r_ack_is_ack;
  assign w_ack_seq    = ack_nak_vld_i ? ack_nak_seq_i    : r_ack_seq;

  assign w_upd_clr = (r_tx_state == TX_BODY && m_axis_tready && r_cur_is_upd) ? r_cur_upd : 3'b000;
  assign w_upd_set = update_fc_req_i | w_timer_hit;

`ifdef DLLP_UPDATEFC_TIMER_EN
  localparam int TW = $clog2(UPDATE_FC_INTERVAL);
  logic [TW-1:0] r_fc_timer;

  // Periodic UpdateFC timer, held at zero outside DL_ACTIVE
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_active) begin
      r_fc_timer <= '0;
    end else if (r_fc_timer == TW'(UPDATE_FC_INTERVAL - 1)) begin
      r_fc_timer <= '0;
    end else begin
      r_fc_timer <= r_fc_timer + TW'(1);
    end
  end

  assign w_timer_hit = (w_active && r_fc_timer == TW'(UPDATE_FC_INTERVAL - 1)) ? 3'b111 : 3'b000;
`else
  assign w_timer_hit = 3'b000;
`endif

  // Pick the next DLLP while idle and build its body
  always_comb begin
    w_load    = 1'b0;
    w_sel_ack = 1'b0;
    w_sel_upd = 3'b000;
    w_cls     = r_fc_idx;
    if (r_tx_state == TX_IDLE && phy_link_up_i) begin
      if (w_in_init) begin
        w_load = 1'b1;
      end else if (w_active) begin
        if (r_ack_pend) begin
          w_load    = 1'b1;
          w_sel_ack = 1'b1;
        end else if (r_upd_pend[0]) begin
          w_load = 1'b1; w_sel_upd = 3'b001; w_cls = 2'd0;
        end else if (r_upd_pend[1]) begin
          w_load = 1'b1; w_sel_upd = 3'b010; w_cls = 2'd1;
        end else if (r_upd_pend[2]) begin
          w_load = 1'b1; w_sel_upd = 3'b100; w_cls = 2'd2;
        end else begin
          w_load = 1'b0;
        end
      end else begin
        w_load = 1'b0;
      end
    end else begin
      w_load = 1'b0;
    end

    case (r_dl_state)
      DL_FC1:  w_base = DLLP_INITFC1_P;
      DL_FC2:  w_base = DLLP_INITFC2_P;
      default: w_base = DLLP_UPDFC_P;
    endcase
    w_type = w_base + {2'b00, w_cls, 4'h0};

    case (w_cls)
      2'd0:    begin w_hdr = rx_fc_ph_i;   w_data = rx_fc_pd_i;   end
      2'd1:    begin w_hdr = rx_fc_nph_i;  w_data = rx_fc_npd_i;  end
      2'd2:    begin w_hdr = rx_fc_cplh_i; w_data = rx_fc_cpld_i; end
      default: begin w_hdr = 8'h00;        w_data = 12'h000;      end
    endcase

    if (w_sel_ack) begin
      w_load_body = pack_acknak(w_ack_is_ack, w_ack_seq);
    end else begin
      w_load_body = pack_fc(w_type, w_hdr, w_data);
    end
  end

  pcie_datalink_crc u_crc (
    .crcIn  (16'hFFFF),
    .data   (r_body),
    .crcOut (w_crc)
  );

  // DL state, pending requests and the transmit sub-FSM with registered AXIS outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dl_state   <= DL_INACTIVE;
      r_tx_state   <= TX_IDLE;
      r_fc_idx     <= 2'd0;
      r_cur_is_upd <= 1'b0;
      r_cur_upd    <= 3'b000;
      r_body       <= 32'h0000_0000;
      r_ack_pend   <= 1'b0;
      r_ack_is_ack <= 1'b0;
      r_ack_seq    <= 12'h000;
      r_upd_pend   <= 3'b000;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tuser      <= '0;
      r_dl_up      <= 1'b0;
    end else begin
      if (w_active) begin
        r_upd_pend <= (r_upd_pend & ~w_upd_clr) | w_upd_set;
        if (w_load && w_sel_ack) begin
          r_ack_pend <= 1'b0;
        end else if (ack_nak_vld_i) begin
          r_ack_pend   <= 1'b1;
          r_ack_is_ack <= ack_nak_is_ack_i;
          r_ack_seq    <= ack_nak_seq_i;
        end else begin
          r_ack_pend <= r_ack_pend;
        end
      end else begin
        r_upd_pend <= 3'b000;
        r_ack_pend <= 1'b0;
      end

      case (r_tx_state)
        TX_IDLE: begin
          if (w_load) begin
            r_body       <= w_load_body;
            r_tdata      <= DATA_WIDTH'(w_load_body);
            r_tkeep      <= KEEP_WIDTH'(4'hF);
            r_tlast      <= 1'b0;
            r_tuser      <= USER_WIDTH'(1'b1);
            r_tvalid     <= 1'b1;
            r_cur_is_upd <= w_active && !w_sel_ack;
            r_cur_upd    <= w_sel_upd;
            r_tx_state   <= TX_BODY;
          end else if (!phy_link_up_i) begin
            r_dl_state <= DL_INACTIVE;
            r_dl_up    <= 1'b0;
            r_fc_idx   <= 2'd0;
          end else if (r_dl_state == DL_INACTIVE) begin
            r_dl_state <= DL_FC1;
            r_fc_idx   <= 2'd0;
          end else begin
            r_tx_state <= TX_IDLE;
          end
        end
        TX_BODY: begin
          if (m_axis_tready) begin
            r_tdata    <= DATA_WIDTH'({16'h0000, ~w_crc});
            r_tkeep    <= KEEP_WIDTH'(4'h3);
            r_tlast    <= 1'b1;
            r_tx_state <= TX_CRC;
          end else begin
            r_tx_state <= TX_BODY;
          end
        end
        TX_CRC: begin
          if (m_axis_tready) begin
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= '0;
            r_tx_state <= TX_IDLE;
            // An init round only advances once its Cpl DLLP has fully gone out
            if (w_in_init) begin
              if (r_fc_idx == 2'd2) begin
                r_fc_idx <= 2'd0;
                if (r_dl_state == DL_FC1 && fc1_values_stored_i) begin
                  r_dl_state <= DL_FC2;
                end else if (r_dl_state == DL_FC2 && fc2_values_stored_i) begin
                  r_dl_state <= DL_ACTIVE;
                  r_dl_up    <= 1'b1;
                end else begin
                  r_dl_state <= r_dl_state;
                end
              end else begin
                r_fc_idx <= r_fc_idx + 2'd1;
              end
            end else begin
              r_fc_idx <= r_fc_idx;
            end
          end else begin
            r_tx_state <= TX_CRC;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign dl_up_o       = r_dl_up;
  assign dl_state_o    = r_dl_state;

endmodule
